seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative shift-subtract (restoring) divider; the division counterpart of the ALU's shift-add multiplier.
//  Accepts a DIVU command from the ALU control Signal bus and produces {remainder, quotient} on a 64-bit result.
//  Sits beside the multiplier in the ALU; the result feeds the HI/LO registers (HI=remainder, LO=quotient).
// PARAMETERS
//  WIDTH     32           operand width; result is 2*WIDTH
//  CNT_W     $clog2(WIDTH) iteration counter width (derived, do not override)
// PORTS
//  clk       in   1        clock, all state updates on rising edge
//  reset     in   1        synchronous, active-high reset
//  dataA     in   WIDTH    dividend, sampled only on accepted start
//  dataB     in   WIDTH    divisor, sampled only on accepted start
//  Signal    in   6        ALU op code; DIVU=6'b011011, DIV=6'b011010 (signed build only)
//  start     in   1        one-cycle command strobe, qualified by Signal
//  busy      out  1        high while an operation is in progress
//  done      out  1        one-cycle pulse, dataOut valid from this cycle
//  dz        out  1        divide-by-zero flag for the last result
//  dataOut   out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, dz=0, dataOut=0, counter=0. Reset mid-operation aborts; no done pulse.
//  - States: IDLE -> CALC -> (FIX) -> DONE -> IDLE. DONE lasts exactly one cycle (done=1).
//  - Accept: start=1 && Signal==DIVU (or DIV if signed) && state in {IDLE, DONE}. Other Signal values ignored.
//    start while busy is ignored (no queueing). Accept in DONE cycle starts next op back-to-back.
//  - Accept cycle (T0): latch dividend->quo, divisor->dvs, rem=0 (WIDTH+1 bits), counter=WIDTH-1, dz=(dataB==0).
//  - CALC, one bit per cycle: {rem,quo} <<= 1; t = rem - {1'b0,dvs}; if t>=0 {rem=t; quo[0]=1}.
//    Counter decrements; leaves CALC after the cycle with counter==0. Exactly WIDTH CALC cycles.
//  - Latency unsigned: done asserted at T0+WIDTH+1 (cycle 33 for WIDTH=32). busy=1 from T0+1 through last CALC/FIX.
//  - Divide by zero: no special path; algorithm yields quotient=all ones, remainder=dividend; dz=1. Same latency.
//  - dataOut updates only in the DONE cycle; holds previous result during CALC and until the next DONE.
//  - done and busy never both high. dz holds until next accepted start.
// CONFIGURATION
//  DIVIDER_SIGNED_EN defined:
//   - Signal DIV accepted. On accept, operands converted to magnitudes; signs latched.
//   - Extra FIX state after CALC (1 cycle): quotient negated if sign(A)^sign(B); remainder takes sign of A.
//   - DIV latency = WIDTH+2 (done at cycle 34); DIVU unchanged, bypasses FIX.
//   - -2^31 / -1 -> quotient 0x8000_0000, remainder 0 (wraps, no trap). DIV by 0: quotient all ones, rem=A, dz=1.
//  Not defined: DIV treated as unknown op (ignored, no busy); FIX state and sign logic absent.
// STRUCTURE
//  - Package alu_pkg: Signal op constants (MUL, DIVU, DIV, OUT), div_state_t enum {IDLE,CALC,FIX,DONE}, WIDTH default.
//  - Sub-module div_sign_fix (combinational abs-in / negate-out helper), instantiated only under DIVIDER_SIGNED_EN.
//  - Core: one FSM always block + datapath registers rem/quo/dvs/counter in seq_divider.
// TESTING
//  1. DIVU 100/7 -> done at cycle 33 after start, dataOut={32'd2, 32'd14}, dz=0.
//  2. DIVU 0xFFFF_FFFF/1 -> quotient 0xFFFF_FFFF, remainder 0; DIVU 5/9 -> quotient 0, remainder 5.
//  3. DIVU 1234/0 -> dz=1, quotient 0xFFFF_FFFF, remainder 1234, same 33-cycle latency.
//  4. start during busy with new operands -> ignored, first result unchanged; start in DONE cycle -> next op done 33 later.
//  5. reset asserted at CALC cycle 10 -> next cycle busy=0, done never pulses, dataOut=0; fresh op then correct.
//  6. (SIGNED_EN) DIV -7/2 -> q=-3 (0xFFFF_FFFD), r=-1, done at cycle 34; DIV 0x8000_0000/-1 -> q=0x8000_0000, r=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes on the Signal bus, divider FSM states and the default operand width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] MUL  = 6'b011000;
  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] DIV  = 6'b011010;
  localparam logic [5:0] OUT  = 6'b010000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: combinational operand-magnitude and result-sign correction for signed DIV.
// Only present when DIVIDER_SIGNED_EN is defined.
`ifdef DIVIDER_SIGNED_EN
module div_sign_fix
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] quo_mag,
  input  logic [WIDTH-1:0] rem_mag,
  input  logic             neg_q,
  input  logic             neg_r,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] quo_out,
  output logic [WIDTH-1:0] rem_out
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Two's-complement negation wraps, so -2^(WIDTH-1) maps onto itself as its own magnitude.
  assign a_mag   = (signed_op && a_in[WIDTH-1]) ? (~a_in + ONE) : a_in;
  assign b_mag   = (signed_op && b_in[WIDTH-1]) ? (~b_in + ONE) : b_in;
  assign quo_out = neg_q ? (~quo_mag + ONE) : quo_mag;
  assign rem_out = neg_r ? (~rem_mag + ONE) : rem_mag;

endmodule
`endif

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per cycle, dataOut={remainder,quotient}.
// Define DIVIDER_SIGNED_EN to accept signed DIV (adds the FIX state and div_sign_fix).
module seq_divider
  import alu_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               dz,
  output logic [2*WIDTH-1:0] dataOut
);

  div_state_t state_r, state_nxt_s, calc_exit_s;

  logic [WIDTH:0]     rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               busy_r, done_r, dz_r;
  logic [2*WIDTH-1:0] dataout_r;

  logic               accept_s, signed_op_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH+1:0]   rem_sh_s, diff_s;
  logic [WIDTH:0]     rem_step_s;
  logic [WIDTH-1:0]   quo_step_s;
  logic [WIDTH-1:0]   res_q_s, res_r_s;

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE)) &&
                    ((Signal == DIVU) || signed_op_s);

`ifdef DIVIDER_SIGNED_EN
  logic             sgn_r, neg_q_r, neg_r_r;
  logic [WIDTH-1:0] fix_q_s, fix_r_s;

  assign signed_op_s = (Signal == DIV);
  assign calc_exit_s = sgn_r ? FIX : DONE;

  div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_op (signed_op_s),
    .a_in      (dataA),
    .b_in      (dataB),
    .quo_mag   (quo_r),
    .rem_mag   (rem_r[WIDTH-1:0]),
    .neg_q     (neg_q_r),
    .neg_r     (neg_r_r),
    .a_mag     (a_mag_s),
    .b_mag     (b_mag_s),
    .quo_out   (fix_q_s),
    .rem_out   (fix_r_s)
  );

  // Sign bookkeeping; a zero divisor keeps the all-ones quotient un-negated.
  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s) begin
      sgn_r   <= signed_op_s;
      neg_q_r <= signed_op_s && (dataA[WIDTH-1] ^ dataB[WIDTH-1]) && (dataB != {WIDTH{1'b0}});
      neg_r_r <= signed_op_s && dataA[WIDTH-1];
    end
  end
`else
  assign signed_op_s = 1'b0;
  assign calc_exit_s = DONE;
  assign a_mag_s     = dataA;
  assign b_mag_s     = dataB;
`endif

  // One restoring step: shift {rem,quo} left, subtract divisor, keep it if non-negative.
  assign rem_sh_s = {rem_r, quo_r[WIDTH-1]};
  assign diff_s   = rem_sh_s - {2'b00, dvs_r};

  // Select restored or subtracted partial remainder for this iteration.
  always_comb begin
    rem_step_s = rem_sh_s[WIDTH:0];
    quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
    if (!diff_s[WIDTH+1]) begin
      rem_step_s = diff_s[WIDTH:0];
      quo_step_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_step_s = rem_sh_s[WIDTH:0];
      quo_step_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Result presented on entry to DONE: straight from the last CALC step, or sign-corrected in FIX.
  always_comb begin
    res_q_s = quo_step_s;
    res_r_s = rem_step_s[WIDTH-1:0];
`ifdef DIVIDER_SIGNED_EN
    if (state_r == FIX) begin
      res_q_s = fix_q_s;
      res_r_s = fix_r_s;
    end else begin
      res_q_s = quo_step_s;
      res_r_s = rem_step_s[WIDTH-1:0];
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = CALC;
        else          state_nxt_s = IDLE;
      end
      CALC: begin
        if (cnt_r == {CNT_W{1'b0}}) state_nxt_s = calc_exit_s;
        else                        state_nxt_s = CALC;
      end
      FIX:  state_nxt_s = DONE;
      DONE: begin
        if (accept_s) state_nxt_s = CALC;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath registers: load on accept, iterate while in CALC.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r <= {(WIDTH+1){1'b0}};
      quo_r <= {WIDTH{1'b0}};
      dvs_r <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      dz_r  <= 1'b0;
    end else if (accept_s) begin
      rem_r <= {(WIDTH+1){1'b0}};
      quo_r <= a_mag_s;
      dvs_r <= b_mag_s;
      cnt_r <= CNT_W'(WIDTH - 1);
      dz_r  <= (dataB == {WIDTH{1'b0}});
    end else if (state_r == CALC) begin
      rem_r <= rem_step_s;
      quo_r <= quo_step_s;
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Registered outputs decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dataout_r <= {(2*WIDTH){1'b0}};
    end else begin
      busy_r <= (state_nxt_s == CALC) || (state_nxt_s == FIX);
      done_r <= (state_nxt_s == DONE);
      if (state_nxt_s == DONE) begin
        dataout_r <= {res_r_s, res_q_s};
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign dz      = dz_r;
  assign dataOut = dataout_r;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider; signed cases run when DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;
  import alu_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   dataA, dataB;
  logic [5:0]     Signal;
  logic           start;
  logic           busy, done, dz;
  logic [2*W-1:0] dataOut;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [2*W-1:0] exp_q[$];
  logic           exp_dz_q[$];
  int             t0_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .dz      (dz),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic [W-1:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  // Present one command for one cycle; queue the expected result if it should be accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op, input bit accepted);
    dataA  = a;
    dataB  = b;
    Signal = op;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    if (accepted) begin
      exp_q.push_back(model(a, b, op == DIV));
      exp_dz_q.push_back(b == 32'd0);
      t0_q.push_back(cyc - 1);
    end
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int guard = 0;
    int t0;
    logic [2*W-1:0] e;
    logic edz;
    while (done !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b required 1", name, done);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: done pulse with nothing expected", name);
    end else begin
      e   = exp_q.pop_front();
      edz = exp_dz_q.pop_front();
      t0  = t0_q.pop_front();
      checks++;
      if ((cyc - t0) != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", name, cyc - t0, exp_lat);
      end
      checks++;
      if (dataOut !== e) begin
        errors++;
        $display("FAIL %s dataOut: got %h required %h", name, dataOut, e);
      end
      checks++;
      if (dz !== edz) begin
        errors++;
        $display("FAIL %s dz: got %b required %b", name, dz, edz);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_with_done: got %b required 0", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dataA = 32'd0; dataB = 32'd0; Signal = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b required 0", done); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset dz: got %b required 0", dz); end
    checks++; if (dataOut !== 64'd0) begin errors++; $display("FAIL reset dataOut: got %h required 0", dataOut); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send(32'd100, 32'd7, DIVU, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic busy_after_accept: got %b required 1", busy); end
    wait_done("divu_100_7", 33);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic done_pulse: got %b required 0", done); end
    checks++;
    if (dataOut !== {32'd2, 32'd14}) begin errors++; $display("FAIL basic hold: got %h required %h", dataOut, {32'd2, 32'd14}); end
  endtask

  task automatic test_edges();
    send(32'hFFFF_FFFF, 32'd1, DIVU, 1'b1);
    wait_done("divu_max_1", 33);
    send(32'd5, 32'd9, DIVU, 1'b1);
    wait_done("divu_5_9", 33);
    send(32'h8000_0001, 32'hFFFF_FFFF, DIVU, 1'b1);
    wait_done("divu_big_divisor", 33);
  endtask

  task automatic test_div_zero();
    send(32'd1234, 32'd0, DIVU, 1'b1);
    wait_done("divu_by_zero", 33);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dz !== 1'b1) begin errors++; $display("FAIL dz_hold: got %b required 1", dz); end
  endtask

  task automatic test_back_to_back();
    send(32'd1000, 32'd3, DIVU, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    send(32'd77, 32'd0, DIVU, 1'b0);
    wait_done("busy_ignore", 33);
    send(32'd50000, 32'd123, DIVU, 1'b1);
    wait_done("b2b_second", 33);
  endtask

  task automatic test_unknown_op();
    int seen = 0;
    send(32'd10, 32'd2, MUL, 1'b0);
`ifndef DIVIDER_SIGNED_EN
    send(32'd10, 32'd2, DIV, 1'b0);
`endif
    repeat (5) begin
      if (busy !== 1'b0 || done !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL unknown_op: busy/done cycles got %0d required 0", seen); end
  endtask

  task automatic test_reset_mid();
    int t0;
    int hits = 0;
    send(32'd9999, 32'd13, DIVU, 1'b0);
    t0 = cyc - 1;
    while ((cyc - t0) < 10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b required 0", busy); end
    checks++; if (dataOut !== 64'd0) begin errors++; $display("FAIL reset_mid dataOut: got %h required 0", dataOut); end
    repeat (40) begin
      if (done !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    checks++;
    if (hits != 0) begin errors++; $display("FAIL reset_mid done_pulses: got %0d required 0", hits); end
    send(32'd81, 32'd9, DIVU, 1'b1);
    wait_done("after_reset", 33);
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    send(32'hFFFF_FFF9, 32'd2, DIV, 1'b1);
    wait_done("div_m7_2", 34);
    send(32'h8000_0000, 32'hFFFF_FFFF, DIV, 1'b1);
    wait_done("div_min_m1", 34);
    send(32'hFFFF_FF9C, 32'd0, DIV, 1'b1);
    wait_done("div_by_zero", 34);
    send(32'd100, 32'hFFFF_FFF9, DIV, 1'b1);
    wait_done("div_100_m7", 34);
    send(32'd100, 32'd7, DIVU, 1'b1);
    wait_done("divu_after_div", 33);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_back_to_back();
    test_unknown_op();
    test_reset_mid();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
